mode_counter: RTL
=================

Name: mode_counter

Overview:
Parametrised successor to the basic load/clear/count counter. Adds up/down direction, a configurable modulus (MAX_VALUE), four terminal-count modes (wrap, saturate, one-shot, reload) and separate carry/borrow/done flags. Used as a general event/timeout counter in CPU support logic, for example cycle counters, delay timers and multi-cycle op sequencing.

Parameters:
DATA_BITS, 8, counter and data width in bits (legal range 2..32)
MAX_VALUE, {DATA_BITS{1'b1}}, terminal value for up-counting; the count range is 0..MAX_VALUE inclusive
RESET_VALUE, 0, value of out after clear; must be <= MAX_VALUE

Ports:
clk  in  1  rising-edge clock
clear  in  1  synchronous active-high reset
data  in  DATA_BITS  load value; also the reload value in MODE_RELOAD
load  in  1  synchronous load of data into out
count  in  1  count enable, one step per cycle
up  in  1  1 = increment, 0 = decrement
mode  in  2  terminal behaviour: 00 wrap, 01 saturate, 10 one-shot, 11 reload
out  out  DATA_BITS  registered count value
carry  out  1  registered one-cycle pulse on an up step taken at MAX_VALUE
borrow  out  1  registered one-cycle pulse on a down step taken at 0
done  out  1  registered sticky flag, one-shot mode terminal reached

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on clear. Everything is sampled on the rising edge of clk.
- Reset values: after a clk edge with clear=1, out=RESET_VALUE, carry=0, borrow=0, done=0.
- Priority per edge: clear > load > count. If clear=1, load and count are ignored. If load=1, count is ignored.
- Load:
  - out <= data when data <= MAX_VALUE; out <= MAX_VALUE when data > MAX_VALUE (clamp).
  - done cleared. carry and borrow are 0 on the following cycle.
- Count (count=1, load=0, clear=0, done=0):
  - Non-terminal up step: out+1. Non-terminal down step: out-1.
  - The terminal condition is out==MAX_VALUE when up=1, out==0 when up=0. At terminal the mode decides the next value.
  - Wrap (00): up gives 0 with carry=1; down gives MAX_VALUE with borrow=1.
  - Saturate (01): out holds. carry (up) or borrow (down) pulses on every attempted step at terminal.
  - One-shot (10): out holds. done<=1, plus the carry/borrow pulse. While done=1, count is ignored; only load or clear releases it.
  - Reload (11): out <= clamped data, with a carry/borrow pulse.
- carry and borrow are registered and high for exactly the one cycle in which out shows the post-terminal value. Both are 0 in every other cycle. They are never high together.
- count=0: out, done and flags hold, except carry and borrow, which return to 0.
- Latency: out reflects load or count one cycle after the edge. No combinational path from any input to any output.
- Inputs up and mode are sampled each edge. A change takes effect on the very next step, and mid-count changes are legal.
- Changing mode away from one-shot while done=1 does not clear done; only load or clear does.
- Arithmetic is unsigned, modulo MAX_VALUE+1. When MAX_VALUE < 2^DATA_BITS-1, values above MAX_VALUE are unreachable.
- A clear during any operation, including while done=1, takes full effect on that edge.

Decomposition:
- Shared package counter_pkg holds mode constants MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10, MODE_RELOAD=2'b11. The same package is reused by timers that instantiate this block.
- No sub-module. Next-value, terminal detect and flag logic sit in one clocked process plus one combinational next-state process.
- Reference model for the bench: a behavioural counter in the test package.

Test Plan:
1. DATA_BITS=8, MAX_VALUE=8'hFF, mode=00, up=1. load=1 with data=8'hF0 for one edge, then count=1 -> out steps F1..FF over 15 cycles; next edge out=00 and carry=1 for exactly one cycle; out=01 after that with carry=0.
2. mode=00, up=0, load data=8'h02, count=1 -> out 01, 00, then FF with borrow=1 for one cycle. carry stays 0 throughout.
3. MAX_VALUE=8'd9, mode=01, up=1, load data=8'd8, count held 4 cycles -> out 9, 9, 9, 9. carry=0 on the first cycle and 1 on each of the following 3 cycles.
4. MAX_VALUE=8'd9, mode=10, load 8'd7, count=1 -> out 8, 9, then holds 9 with done=1 and a single carry pulse. Load data=8'd3 clears done and out=3. Load data=8'd20 instead -> out=9 (clamped).
5. mode=11, up=1, data=8'h10, out at FF, count=1 -> out=10 with carry=1. Simultaneous load=1 and count=1 with data=8'h55 -> out=55 and carry=0.
6. Counting with done=1 and clear pulsed mid-sequence -> out=RESET_VALUE, done=0, carry=0 and borrow=0 on the next cycle, even with load=1 and count=1 on the same edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for counter-style blocks: terminal-count behaviour
// selection used by mode_counter and the timers built on top of it.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RELOAD  = 2'b11
  } mode_e;

endpackage : counter_pkg

// File: rtl/mode_counter.sv
// Up/down counter with a configurable modulus and four terminal-count modes.
// It provides one-cycle carry/borrow pulses and a sticky one-shot done flag.
module mode_counter
  import counter_pkg::*;
#(
  parameter int                   DATA_BITS   = 8,
  parameter logic [DATA_BITS-1:0] MAX_VALUE   = {DATA_BITS{1'b1}},
  parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 load,
  input  logic                 count,
  input  logic                 up,
  input  logic [1:0]           mode,
  output logic [DATA_BITS-1:0] out,
  output logic                 carry,
  output logic                 borrow,
  output logic                 done
);

  localparam logic [DATA_BITS-1:0] ONE = {{(DATA_BITS-1){1'b0}}, 1'b1};

  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 carry_q, carry_d;
  logic                 borrow_q, borrow_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] data_clamped;
  logic                 at_term;
  mode_e                mode_s;

  assign mode_s       = mode_e'(mode);
  assign data_clamped = (data > MAX_VALUE) ? MAX_VALUE : data;
  assign at_term      = up ? (out_q == MAX_VALUE) : (out_q == '0);

  // Clear is handled in the register process; this covers load > count.
  always_comb begin
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    done_d   = done_q;
    if (load) begin
      out_d  = data_clamped;
      done_d = 1'b0;
    end else if (count && !done_q) begin
      if (!at_term) begin
        out_d = up ? (out_q + ONE) : (out_q - ONE);
      end else begin
        carry_d  = up;
        borrow_d = ~up;
        case (mode_s)
          MODE_WRAP:    out_d  = up ? '0 : MAX_VALUE;
          MODE_SAT:     out_d  = out_q;
          MODE_ONESHOT: done_d = 1'b1;
          MODE_RELOAD:  out_d  = data_clamped;
          default:      out_d  = out_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      out_q    <= RESET_VALUE;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign out    = out_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign done   = done_q;

endmodule : mode_counter
